// File: rtl/pool_window_packer.sv
// pool_window_packer: packs 8 parallel byte lanes into per-lane pool windows of P bytes (1..7).
// Latency: window valid pulses in the cycle after the beat that completes or flushes the window.
// Backpressure: none; every accepted beat is consumed and downstream takes every valid pulse.
//
// Ports:
//   clk_cal, rst_cal_n          calculation clock (rising edge), async active-low reset
//   P                           window size, latched at the first beat of each window
//   Clr                         synchronous abort; drops the partial window and zeroes Win_Cnt
//   In_Data/_vld/_last          8 lane bytes per beat; _last marks the final beat of a row
//   Pool_IData1..8              assembled window per lane, held between emissions
//   Pool_IData_vld1..8          one-cycle window valid pulse, identical on all lanes
//   Win_Cnt                     saturating count of emitted windows
//   Busy                        registered, high while a partial window is held
module pool_window_packer #(
  parameter int          LANES    = 8,
  parameter logic [7:0]  PAD_BYTE = 8'h80,
  parameter int          CNT_W    = 16
) (
  input  logic             clk_cal,
  input  logic             rst_cal_n,
  input  logic [2:0]       P,
  input  logic             Clr,
  input  logic [63:0]      In_Data,
  input  logic             In_Data_vld,
  input  logic             In_Data_last,
  output logic [55:0]      Pool_IData1,
  output logic [55:0]      Pool_IData2,
  output logic [55:0]      Pool_IData3,
  output logic [55:0]      Pool_IData4,
  output logic [55:0]      Pool_IData5,
  output logic [55:0]      Pool_IData6,
  output logic [55:0]      Pool_IData7,
  output logic [55:0]      Pool_IData8,
  output logic             Pool_IData_vld1,
  output logic             Pool_IData_vld2,
  output logic             Pool_IData_vld3,
  output logic             Pool_IData_vld4,
  output logic             Pool_IData_vld5,
  output logic             Pool_IData_vld6,
  output logic             Pool_IData_vld7,
  output logic             Pool_IData_vld8,
  output logic [CNT_W-1:0] Win_Cnt,
  output logic             Busy
);

  localparam int SLOTS = 7;

  // Busy is simply "in ACCUM"; the byte count lives in cnt_q.
  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ACCUM = 1'b1
  } state_t;

  state_t             state_q;
  logic [2:0]         cnt_q;
  logic [2:0]         p_lat;
  logic [55:0]        buf_q   [LANES];
  logic [55:0]        pool_q  [LANES];
  logic               vld_q;
  logic [CNT_W-1:0]   win_cnt_q;

  logic [2:0]         eff_p;
  logic [3:0]         cnt_inc;
  logic               take;
  logic               complete;
  logic               flush;
  logic               emit;
  logic [55:0]        buf_d   [LANES];
  logic [55:0]        win     [LANES];
  logic [7:0]         slot;

  // Window size in force for this beat: a new window uses the live P,
  // a window in progress keeps the size it started with.
  always_comb begin
    eff_p    = (cnt_q == 3'd0) ? P : p_lat;
    take     = In_Data_vld && !Clr && (eff_p != 3'd0);
    cnt_inc  = {1'b0, cnt_q} + 4'd1;
    complete = take && (cnt_inc == {1'b0, eff_p});
    flush    = take && In_Data_last && !complete;
    emit     = complete || flush;
  end

  // Merge the incoming byte into slot cnt_q, and build the outgoing window:
  // slots past the last real byte are zero on a full window and PAD_BYTE on a flush.
  always_comb begin
    slot = 8'h00;
    for (int k = 0; k < LANES; k++) begin
      buf_d[k] = buf_q[k];
      win[k]   = '0;
      for (int j = 0; j < SLOTS; j++) begin
        slot = (3'(j) == cnt_q) ? In_Data[8*k +: 8] : buf_q[k][8*j +: 8];
        buf_d[k][8*j +: 8] = slot;
        if (3'(j) <= cnt_q) begin
          win[k][8*j +: 8] = slot;
        end else if (complete) begin
          win[k][8*j +: 8] = 8'h00;
        end else begin
          win[k][8*j +: 8] = PAD_BYTE;
        end
      end
    end
  end

  always_ff @(posedge clk_cal or negedge rst_cal_n) begin
    if (!rst_cal_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 3'd0;
      p_lat     <= 3'd0;
      vld_q     <= 1'b0;
      win_cnt_q <= '0;
      for (int k = 0; k < LANES; k++) begin
        buf_q[k]  <= '0;
        pool_q[k] <= '0;
      end
    end else if (Clr) begin
      // Abort: any beat presented alongside Clr is dropped; the last emitted
      // window stays visible on Pool_IData.
      state_q   <= S_IDLE;
      cnt_q     <= 3'd0;
      vld_q     <= 1'b0;
      win_cnt_q <= '0;
      for (int k = 0; k < LANES; k++) begin
        buf_q[k] <= '0;
      end
    end else begin
      vld_q <= emit;
      // P is captured on every beat that arrives at a window boundary, even P==0.
      if (In_Data_vld && (cnt_q == 3'd0)) begin
        p_lat <= P;
      end
      if (emit) begin
        state_q <= S_IDLE;
        cnt_q   <= 3'd0;
        if (win_cnt_q != {CNT_W{1'b1}}) begin
          win_cnt_q <= win_cnt_q + 1'b1;
        end
        // Buffers restart from zero so a shorter next window never sees stale bytes.
        for (int k = 0; k < LANES; k++) begin
          pool_q[k] <= win[k];
          buf_q[k]  <= '0;
        end
      end else if (take) begin
        state_q <= S_ACCUM;
        cnt_q   <= cnt_q + 3'd1;
        for (int k = 0; k < LANES; k++) begin
          buf_q[k] <= buf_d[k];
        end
      end
    end
  end

  assign Pool_IData1 = pool_q[0];
  assign Pool_IData2 = pool_q[1];
  assign Pool_IData3 = pool_q[2];
  assign Pool_IData4 = pool_q[3];
  assign Pool_IData5 = pool_q[4];
  assign Pool_IData6 = pool_q[5];
  assign Pool_IData7 = pool_q[6];
  assign Pool_IData8 = pool_q[7];

  assign Pool_IData_vld1 = vld_q;
  assign Pool_IData_vld2 = vld_q;
  assign Pool_IData_vld3 = vld_q;
  assign Pool_IData_vld4 = vld_q;
  assign Pool_IData_vld5 = vld_q;
  assign Pool_IData_vld6 = vld_q;
  assign Pool_IData_vld7 = vld_q;
  assign Pool_IData_vld8 = vld_q;

  assign Win_Cnt = win_cnt_q;
  assign Busy    = (state_q == S_ACCUM);

endmodule

// File: tb/tb_pool_window_packer.sv
// Testbench for pool_window_packer: directed vector table plus randomized traffic
// against a queue-based reference model. Win_Cnt is narrowed so saturation is reachable.
module tb_pool_window_packer;

  localparam int CW = 4;

  logic          clk_cal = 1'b0;
  logic          rst_cal_n = 1'b0;
  logic [2:0]    P = 3'd0;
  logic          Clr = 1'b0;
  logic [63:0]   In_Data = '0;
  logic          In_Data_vld = 1'b0;
  logic          In_Data_last = 1'b0;
  logic [55:0]   Pool_IData1, Pool_IData2, Pool_IData3, Pool_IData4;
  logic [55:0]   Pool_IData5, Pool_IData6, Pool_IData7, Pool_IData8;
  logic          Pool_IData_vld1, Pool_IData_vld2, Pool_IData_vld3, Pool_IData_vld4;
  logic          Pool_IData_vld5, Pool_IData_vld6, Pool_IData_vld7, Pool_IData_vld8;
  logic [CW-1:0] Win_Cnt;
  logic          Busy;

  pool_window_packer #(.CNT_W(CW)) dut (
    .clk_cal(clk_cal), .rst_cal_n(rst_cal_n), .P(P), .Clr(Clr),
    .In_Data(In_Data), .In_Data_vld(In_Data_vld), .In_Data_last(In_Data_last),
    .Pool_IData1(Pool_IData1), .Pool_IData2(Pool_IData2), .Pool_IData3(Pool_IData3),
    .Pool_IData4(Pool_IData4), .Pool_IData5(Pool_IData5), .Pool_IData6(Pool_IData6),
    .Pool_IData7(Pool_IData7), .Pool_IData8(Pool_IData8),
    .Pool_IData_vld1(Pool_IData_vld1), .Pool_IData_vld2(Pool_IData_vld2),
    .Pool_IData_vld3(Pool_IData_vld3), .Pool_IData_vld4(Pool_IData_vld4),
    .Pool_IData_vld5(Pool_IData_vld5), .Pool_IData_vld6(Pool_IData_vld6),
    .Pool_IData_vld7(Pool_IData_vld7), .Pool_IData_vld8(Pool_IData_vld8),
    .Win_Cnt(Win_Cnt), .Busy(Busy)
  );

  always #5 clk_cal = ~clk_cal;

  logic [55:0] dq [8];
  logic [7:0]  vlds;
  assign dq[0] = Pool_IData1;
  assign dq[1] = Pool_IData2;
  assign dq[2] = Pool_IData3;
  assign dq[3] = Pool_IData4;
  assign dq[4] = Pool_IData5;
  assign dq[5] = Pool_IData6;
  assign dq[6] = Pool_IData7;
  assign dq[7] = Pool_IData8;
  assign vlds = {Pool_IData_vld8, Pool_IData_vld7, Pool_IData_vld6, Pool_IData_vld5,
                 Pool_IData_vld4, Pool_IData_vld3, Pool_IData_vld2, Pool_IData_vld1};

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  // Apply one cycle of inputs at the falling edge, then sample just after the rising edge.
  task automatic drive(input logic [2:0] p, input logic clr, input logic vld,
                       input logic last, input logic [63:0] data);
    @(negedge clk_cal);
    P = p; Clr = clr; In_Data_vld = vld; In_Data_last = last; In_Data = data;
    @(posedge clk_cal);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [2:0]    p;
    logic          clr;
    logic          vld;
    logic          last;
    logic [7:0]    b;
    logic          e_vld;
    logic [55:0]   e_d1;
    logic [CW-1:0] e_wcnt;
    logic          e_busy;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic [2:0] p, input logic clr, input logic vld,
                              input logic last, input logic [7:0] b, input logic e_vld,
                              input logic [55:0] e_d1, input int e_wcnt, input logic e_busy);
    vec_t v;
    v.p = p; v.clr = clr; v.vld = vld; v.last = last; v.b = b;
    v.e_vld = e_vld; v.e_d1 = e_d1; v.e_wcnt = CW'(e_wcnt); v.e_busy = e_busy;
    tbl.push_back(v);
  endfunction

  // ---------------- reference model ----------------
  // A window is just the list of beats collected so far; lane k slot j is byte k of beat j.
  logic [63:0] beats[$];
  int          wsize;
  logic        m_vld;
  logic [55:0] m_data [8];
  int          m_wcnt;

  task automatic model_reset();
    beats.delete();
    wsize = 0; m_vld = 1'b0; m_wcnt = 0;
    for (int k = 0; k < 8; k++) m_data[k] = '0;
  endtask

  task automatic model_step(input logic [2:0] p, input logic clr, input logic vld,
                            input logic last, input logic [63:0] data);
    int n;
    m_vld = 1'b0;
    if (clr) begin
      beats.delete();
      m_wcnt = 0;
    end else if (vld) begin
      if (beats.size() == 0) wsize = int'(p);
      if (wsize != 0) begin
        beats.push_back(data);
        n = beats.size();
        if (n == wsize || last) begin
          for (int k = 0; k < 8; k++) begin
            for (int j = 0; j < 7; j++) begin
              if (j < n)           m_data[k][8*j +: 8] = beats[j][8*k +: 8];
              else if (n == wsize) m_data[k][8*j +: 8] = 8'h00;
              else                 m_data[k][8*j +: 8] = 8'h80;
            end
          end
          beats.delete();
          m_vld = 1'b1;
          if (m_wcnt < (1 << CW) - 1) m_wcnt++;
        end
      end
    end
  endtask

  initial begin
    logic [2:0]  rp;
    logic        rc, rv, rl;
    logic [63:0] rd;

    // Reset held with input activity: everything stays zero.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_cal);
      P = 3'd3; In_Data = 64'hFFFF_FFFF_FFFF_FFFF; In_Data_vld = (i % 2 == 0);
      @(posedge clk_cal);
      #1;
      chk("rst_vld",  64'(vlds), 64'h0);
      chk("rst_d1",   64'(Pool_IData1), 64'h0);
      chk("rst_d8",   64'(Pool_IData8), 64'h0);
      chk("rst_wcnt", 64'(Win_Cnt), 64'h0);
      chk("rst_busy", 64'(Busy), 64'h0);
    end
    @(negedge clk_cal);
    In_Data_vld = 1'b0;
    rst_cal_n = 1'b1;

    // Full window P=3, then hold and clear.
    add(3, 0, 1, 0, 8'h11, 0, 56'h0, 0, 1);
    add(3, 0, 1, 0, 8'h22, 0, 56'h0, 0, 1);
    add(3, 0, 1, 0, 8'h33, 1, 56'h00000000332211, 1, 0);
    add(3, 0, 0, 0, 8'h00, 0, 56'h00000000332211, 1, 0);
    add(3, 1, 0, 0, 8'h00, 0, 56'h00000000332211, 0, 0);
    // Row-end flush with padding, P=4.
    add(4, 0, 1, 0, 8'h05, 0, 56'h00000000332211, 0, 1);
    add(4, 0, 1, 1, 8'h06, 1, 56'h80808080800605, 1, 0);
    add(4, 1, 0, 0, 8'h00, 0, 56'h80808080800605, 0, 0);
    // Continuous P=1: a window every cycle.
    for (int i = 0; i < 10; i++)
      add(1, 0, 1, 0, 8'(8'hA0 + i), 1, 56'(8'hA0 + i), i + 1, 0);
    // P change mid-window is ignored until the next window.
    add(2, 0, 1, 0, 8'h41, 0, 56'h000000000000A9, 10, 1);
    add(5, 0, 1, 0, 8'h42, 1, 56'h00000000004241, 11, 0);
    for (int i = 0; i < 4; i++)
      add(5, 0, 1, 0, 8'(8'h51 + i), 0, 56'h00000000004241, 11, 1);
    add(5, 0, 1, 0, 8'h55, 1, 56'h00005554535251, 12, 0);
    // Clr mid-window, beat presented with Clr is dropped.
    add(3, 0, 1, 0, 8'h61, 0, 56'h00005554535251, 12, 1);
    add(3, 0, 1, 0, 8'h62, 0, 56'h00005554535251, 12, 1);
    add(3, 1, 1, 0, 8'h63, 0, 56'h00005554535251, 0, 0);
    add(3, 0, 1, 0, 8'h71, 0, 56'h00005554535251, 0, 1);
    add(3, 0, 1, 0, 8'h72, 0, 56'h00005554535251, 0, 1);
    add(3, 0, 1, 0, 8'h73, 1, 56'h00000000737271, 1, 0);
    // P=0 discards beats.
    for (int i = 0; i < 4; i++)
      add(0, 0, 1, (i == 3), 8'(8'hE0 + i), 0, 56'h00000000737271, 1, 0);
    // Last beat that also completes the window: no padding.
    add(2, 0, 1, 0, 8'h81, 0, 56'h00000000737271, 1, 1);
    add(2, 0, 1, 1, 8'h82, 1, 56'h00000000008281, 2, 0);

    foreach (tbl[i]) begin
      drive(tbl[i].p, tbl[i].clr, tbl[i].vld, tbl[i].last, {8{tbl[i].b}});
      chk($sformatf("tbl%0d_vld", i),  64'(vlds), {56'h0, {8{tbl[i].e_vld}}});
      chk($sformatf("tbl%0d_d1", i),   64'(Pool_IData1), 64'(tbl[i].e_d1));
      chk($sformatf("tbl%0d_wcnt", i), 64'(Win_Cnt), 64'(tbl[i].e_wcnt));
      chk($sformatf("tbl%0d_busy", i), 64'(Busy), 64'(tbl[i].e_busy));
    end

    // Randomized traffic against the reference model.
    @(negedge clk_cal);
    In_Data_vld = 1'b0; Clr = 1'b0;
    rst_cal_n = 1'b0;
    @(negedge clk_cal);
    rst_cal_n = 1'b1;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      rp = 3'($urandom_range(0, 7));
      rc = ($urandom_range(0, 199) == 0);
      rv = ($urandom_range(0, 4) != 0);
      rl = ($urandom_range(0, 7) == 0);
      rd = {$urandom, $urandom};
      model_step(rp, rc, rv, rl, rd);
      drive(rp, rc, rv, rl, rd);
      chk("rnd_vld", 64'(vlds), {56'h0, {8{m_vld}}});
      for (int k = 0; k < 8; k++)
        chk($sformatf("rnd_d%0d", k + 1), 64'(dq[k]), 64'(m_data[k]));
      chk("rnd_wcnt", 64'(Win_Cnt), 64'(m_wcnt));
      chk("rnd_busy", 64'(Busy), 64'(beats.size() != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
